mem_arbiter: RTL and testbench

- Shares the single-port program/data memory between two requesters.
  - Port A: CPU, high priority.
  - Port B: loader/debug master, low priority, starvation-guarded.
- Sits between the requesters and the memory instance, on the divided CPU clock.
- Serialises accesses with a three-state FSM and returns read data to the owner with a one-cycle valid pulse.

---
 rtl/mem_arbiter_if.sv | 77 +++++++
 rtl/mem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
//   Bundles the two requester ports (A = CPU, B = loader/debug), the memory
//   side and the busy flag of mem_arbiter.
//
//   Handshake (both requester ports): a requester raises req with we/addr/
//   wdata stable and keeps it high until it sees gnt = 1. At that clock edge
//   it either drops req or presents its next request; a req still high in
//   the following IDLE cycle is a new request. Read data returns later as a
//   one-cycle rvalid pulse with rdata, and rdata holds until the next read by
//   the same port.
//
//   Modports:
//     slave  - the arbiter side.
//     master - the environment side: the requesters and the memory, which
//              drives mem_out.
//
//   Optional MEM_ARBITER_STATS_EN adds a_cnt, b_cnt and starve.
// ---------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16
);
    logic                  a_req;
    logic                  a_we;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [DATA_WIDTH-1:0] a_wdata;
    logic                  a_gnt;
    logic                  a_rvalid;
    logic [DATA_WIDTH-1:0] a_rdata;

    logic                  b_req;
    logic                  b_we;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [DATA_WIDTH-1:0] b_wdata;
    logic                  b_gnt;
    logic                  b_rvalid;
    logic [DATA_WIDTH-1:0] b_rdata;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_data;
    logic [DATA_WIDTH-1:0] mem_out;

    logic                  busy;
`ifdef MEM_ARBITER_STATS_EN
    logic [7:0]            a_cnt;
    logic [7:0]            b_cnt;
    logic [0:0]            starve;
`endif

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_gnt, a_rvalid, a_rdata,
        input  b_req, b_we, b_addr, b_wdata,
        output b_gnt, b_rvalid, b_rdata,
        output mem_addr, mem_we, mem_data,
        input  mem_out,
        output busy
`ifdef MEM_ARBITER_STATS_EN
        , output a_cnt, b_cnt, starve
`endif
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_gnt, a_rvalid, a_rdata,
        output b_req, b_we, b_addr, b_wdata,
        input  b_gnt, b_rvalid, b_rdata,
        input  mem_addr, mem_we, mem_data,
        output mem_out,
        input  busy
`ifdef MEM_ARBITER_STATS_EN
        , input a_cnt, b_cnt, starve
`endif
    );
endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-port memory between port A (CPU, high priority) and
//   port B (loader/debug, low priority with a starvation guard). Accesses are
//   serialised by an IDLE -> ACCESS (-> RESP) FSM; every output is a register.
//
//   Ports:
//     clk     - clock, rising edge
//     rst     - asynchronous reset, active high
//     bus     - mem_arbiter_if.slave: A/B request ports, memory side, busy
//     state_o - current FSM state (0 IDLE, 1 ACCESS, 2 RESP) for debug
//
//   Timing, request sampled in IDLE at cycle 0: gnt and mem_we at cycle 1,
//   read rvalid at cycle 3; the next arbitration is at cycle 2 after a write
//   and at cycle 3 after a read.
//
//   Optional feature macro: MEM_ARBITER_STATS_EN (grant counters a_cnt/b_cnt
//   and sticky starve flag).
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_BURST  = 4
) (
    input  logic           clk,
    input  logic           rst,
    mem_arbiter_if.slave   bus,
    output logic [1:0]     state_o
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

    state_t                state_q;
    logic                  owner_b_q;   // 0 = A owns the access, 1 = B
    logic                  we_q;
    logic                  busy_q;
    logic                  a_gnt_q, b_gnt_q;
    logic                  a_rvalid_q, b_rvalid_q;
    logic                  mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_data_q;
    logic [DATA_WIDTH-1:0] a_rdata_q, b_rdata_q;
    logic [3:0]            burst_q, burst_d;

    logic                  grant_now;
    logic                  pick_b;

    // A wins ties unless A has used up its burst while B is waiting.
    always_comb begin
        grant_now = (state_q == S_IDLE) && (bus.a_req || bus.b_req);
        pick_b    = bus.b_req && (!bus.a_req || (burst_q == BURST_MAX));
        burst_d   = burst_q;
        if (grant_now) begin
            if (pick_b || !bus.b_req) begin
                burst_d = 4'd0;
            end else if (burst_q != BURST_MAX) begin
                burst_d = burst_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            owner_b_q  <= 1'b0;
            we_q       <= 1'b0;
            busy_q     <= 1'b0;
            a_gnt_q    <= 1'b0;
            b_gnt_q    <= 1'b0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
            burst_q    <= 4'd0;
        end else begin
            // Pulses default low; each is raised for exactly one cycle below.
            a_gnt_q    <= 1'b0;
            b_gnt_q    <= 1'b0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            mem_we_q   <= 1'b0;
            burst_q    <= burst_d;
            case (state_q)
                S_IDLE: begin
                    if (grant_now) begin
                        // Register the winner's access so that gnt and
                        // mem_we are visible together during ACCESS.
                        owner_b_q  <= pick_b;
                        we_q       <= pick_b ? bus.b_we    : bus.a_we;
                        mem_we_q   <= pick_b ? bus.b_we    : bus.a_we;
                        mem_addr_q <= pick_b ? bus.b_addr  : bus.a_addr;
                        mem_data_q <= pick_b ? bus.b_wdata : bus.a_wdata;
                        a_gnt_q    <= !pick_b;
                        b_gnt_q    <= pick_b;
                        busy_q     <= 1'b1;
                        state_q    <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    // A write completes here; a read waits one more cycle
                    // for the memory's registered output.
                    state_q <= we_q ? S_IDLE : S_RESP;
                    busy_q  <= !we_q;
                end
                S_RESP: begin
                    if (owner_b_q) begin
                        b_rdata_q  <= bus.mem_out;
                        b_rvalid_q <= 1'b1;
                    end else begin
                        a_rdata_q  <= bus.mem_out;
                        a_rvalid_q <= 1'b1;
                    end
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.a_gnt    = a_gnt_q;
    assign bus.b_gnt    = b_gnt_q;
    assign bus.a_rvalid = a_rvalid_q;
    assign bus.b_rvalid = b_rvalid_q;
    assign bus.a_rdata  = a_rdata_q;
    assign bus.b_rdata  = b_rdata_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_we   = mem_we_q;
    assign bus.mem_data = mem_data_q;
    assign bus.busy     = busy_q;
    assign state_o      = state_q;

`ifdef MEM_ARBITER_STATS_EN
    logic [7:0] a_cnt_q, b_cnt_q;
    logic       starve_q;

    // Counters step on the same edge that raises the matching gnt pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_cnt_q  <= 8'd0;
            b_cnt_q  <= 8'd0;
            starve_q <= 1'b0;
        end else if (grant_now) begin
            if (pick_b) begin
                if (b_cnt_q != 8'hFF) b_cnt_q <= b_cnt_q + 8'd1;
                // B only beats a requesting A when the burst guard fires.
                if (bus.a_req) starve_q <= 1'b1;
            end else begin
                if (a_cnt_q != 8'hFF) a_cnt_q <= a_cnt_q + 8'd1;
            end
        end
    end

    assign bus.a_cnt  = a_cnt_q;
    assign bus.b_cnt  = b_cnt_q;
    assign bus.starve = starve_q;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    logic       clk;
    logic       rst;
    logic [1:0] state_dbg;
    int         n_total;
    int         n_bad;

    logic [15:0] a_exp_q[$];
    logic [15:0] b_exp_q[$];

    // Backdoor load port of the memory model.
    logic        bd_we;
    logic [5:0]  bd_addr;
    logic [15:0] bd_data;
    logic [15:0] mem [0:63];

    mem_arbiter_if #(.ADDR_WIDTH(6), .DATA_WIDTH(16)) bus ();

    mem_arbiter #(.ADDR_WIDTH(6), .DATA_WIDTH(16), .MAX_BURST(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .state_o (state_dbg)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port memory with registered read.
    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_data;
        bus.mem_out <= mem[bus.mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every rvalid must match the oldest expected read.
    always @(negedge clk) begin
        if (!rst && bus.a_rvalid) begin
            if (a_exp_q.size() == 0) check("a_rvalid_unexpected", 1, 0);
            else check("a_rdata_sb", bus.a_rdata, a_exp_q.pop_front());
        end
        if (!rst && bus.b_rvalid) begin
            if (b_exp_q.size() == 0) check("b_rvalid_unexpected", 1, 0);
            else check("b_rdata_sb", bus.b_rdata, b_exp_q.pop_front());
        end
    end

    // Driver tasks
    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic drive_a(input logic we, input logic [5:0] addr, input logic [15:0] wd);
        bus.a_req = 1'b1; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wd;
    endtask

    task automatic drive_b(input logic we, input logic [5:0] addr, input logic [15:0] wd);
        bus.b_req = 1'b1; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wd;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_a_gnt"},    bus.a_gnt,    0);
        check({tag, "_b_gnt"},    bus.b_gnt,    0);
        check({tag, "_a_rvalid"}, bus.a_rvalid, 0);
        check({tag, "_b_rvalid"}, bus.b_rvalid, 0);
        check({tag, "_a_rdata"},  bus.a_rdata,  0);
        check({tag, "_b_rdata"},  bus.b_rdata,  0);
        check({tag, "_mem_addr"}, bus.mem_addr, 0);
        check({tag, "_mem_we"},   bus.mem_we,   0);
        check({tag, "_mem_data"}, bus.mem_data, 0);
        check({tag, "_busy"},     bus.busy,     0);
        check({tag, "_state"},    state_dbg,    0);
`ifdef MEM_ARBITER_STATS_EN
        check({tag, "_a_cnt"},    bus.a_cnt,    0);
        check({tag, "_b_cnt"},    bus.b_cnt,    0);
        check({tag, "_starve"},   bus.starve,   0);
`endif
    endtask

    initial begin
        int na_before;
        int nb;
        int na_after;
        bit done;

        n_total = 0; n_bad = 0;
        rst = 1'b1;
        bus.a_req = 0; bus.a_we = 0; bus.a_addr = '0; bus.a_wdata = '0;
        bus.b_req = 0; bus.b_we = 0; bus.b_addr = '0; bus.b_wdata = '0;
        bd_we = 1'b1; bd_addr = 6'd5; bd_data = 16'h1234;
        step();
        bd_we = 1'b0;
        step();
        check_all_zero("rst");
        rst = 1'b0;
        step();

        // A read of address 5
        drive_a(1'b0, 6'd5, 16'h0);
        a_exp_q.push_back(16'h1234);
        step();                                   // cycle 1: ACCESS
        check("rd_a_gnt", bus.a_gnt, 1);
        check("rd_b_gnt", bus.b_gnt, 0);
        check("rd_mem_we", bus.mem_we, 0);
        check("rd_mem_addr", bus.mem_addr, 5);
        check("rd_busy", bus.busy, 1);
        bus.a_req = 0;
        step();                                   // cycle 2: RESP
        check("rd_gnt_pulse", bus.a_gnt, 0);
        check("rd_rvalid_early", bus.a_rvalid, 0);
        step();                                   // cycle 3: IDLE + rvalid
        check("rd_a_rvalid", bus.a_rvalid, 1);
        check("rd_a_rdata", bus.a_rdata, 16'h1234);
        check("rd_b_rvalid", bus.b_rvalid, 0);
        check("rd_busy_end", bus.busy, 0);

        // B write BEEF to address 9
        drive_b(1'b1, 6'd9, 16'hBEEF);
        step();
        check("wr_b_gnt", bus.b_gnt, 1);
        check("wr_a_gnt", bus.a_gnt, 0);
        check("wr_mem_we", bus.mem_we, 1);
        check("wr_mem_addr", bus.mem_addr, 9);
        check("wr_mem_data", bus.mem_data, 16'hBEEF);
        bus.b_req = 0;
        step();                                   // cycle 2: IDLE again
        check("wr_mem_we_off", bus.mem_we, 0);
        check("wr_busy_end", bus.busy, 0);

        // A reads back address 9
        drive_a(1'b0, 6'd9, 16'h0);
        a_exp_q.push_back(16'hBEEF);
        step();
        check("rb_a_gnt", bus.a_gnt, 1);
        bus.a_req = 0;
        step();
        step();
        check("rb_a_rvalid", bus.a_rvalid, 1);
        check("rb_a_rdata", bus.a_rdata, 16'hBEEF);
        check("rb_b_rdata_untouched", bus.b_rdata, 0);

        // B reads address 5; A's rdata must stay put
        drive_b(1'b0, 6'd5, 16'h0);
        b_exp_q.push_back(16'h1234);
        step();
        check("brd_b_gnt", bus.b_gnt, 1);
        bus.b_req = 0;
        step();
        step();
        check("brd_b_rvalid", bus.b_rvalid, 1);
        check("brd_b_rdata", bus.b_rdata, 16'h1234);
        check("brd_a_rdata_untouched", bus.a_rdata, 16'hBEEF);
        check("brd_a_rvalid", bus.a_rvalid, 0);

        // Simultaneous: A write wins, then B read follows
        drive_a(1'b1, 6'd3, 16'h1111);
        drive_b(1'b0, 6'd9, 16'h0);
        b_exp_q.push_back(16'hBEEF);
        step();                                   // cycle 1
        check("sim_a_gnt", bus.a_gnt, 1);
        check("sim_b_gnt_wait", bus.b_gnt, 0);
        check("sim_mem_addr_a", bus.mem_addr, 3);
        bus.a_req = 0;
        step();                                   // cycle 2: IDLE
        check("sim_busy_gap", bus.busy, 0);
        check("sim_b_gnt_gap", bus.b_gnt, 0);
        step();                                   // cycle 3: B ACCESS
        check("sim_b_gnt", bus.b_gnt, 1);
        check("sim_mem_addr_b", bus.mem_addr, 9);
        check("sim_mem_we_b", bus.mem_we, 0);
        bus.b_req = 0;
        step();
        step();                                   // cycle 5
        check("sim_b_rvalid", bus.b_rvalid, 1);
        check("sim_b_rdata", bus.b_rdata, 16'hBEEF);

        // Starvation guard: A streams writes while B waits
        do_reset();
        drive_a(1'b1, 6'd10, 16'hA5A5);
        drive_b(1'b1, 6'd20, 16'h2222);
        na_before = 0; nb = 0; na_after = 0; done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            step();
            if (bus.a_gnt && bus.b_gnt) check("starve_double_gnt", 1, 0);
            if (bus.a_gnt) begin
                if (nb == 0) na_before++;
                else begin
                    na_after++;
                    bus.a_req = 0;
                    done = 1;
                end
            end
            if (bus.b_gnt) begin
                nb++;
                bus.b_req = 0;
                check("starve_b_mem_addr", bus.mem_addr, 20);
`ifdef MEM_ARBITER_STATS_EN
                check("starve_flag", bus.starve, 1);
                check("starve_a_cnt", bus.a_cnt, 4);
                check("starve_b_cnt", bus.b_cnt, 1);
`endif
            end
        end
        bus.a_req = 0;
        bus.b_req = 0;
        check("starve_a_burst", na_before, 4);
        check("starve_b_grants", nb, 1);
        check("starve_a_resumed", na_after, 1);
        step();
        step();

        // Reset during RESP drops the read
        drive_a(1'b0, 6'd5, 16'h0);
        step();
        check("rr_a_gnt", bus.a_gnt, 1);
        bus.a_req = 0;
        step();                                   // RESP
        check("rr_in_resp", state_dbg, 2);
        rst = 1'b1;
        #1;
        check_all_zero("rr");
        step();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            check("rr_no_rvalid", bus.a_rvalid, 0);
        end
        check("rr_state_idle", state_dbg, 0);
        check("rr_busy", bus.busy, 0);

        // Idle stability after a B write to address 7
        drive_b(1'b1, 6'd7, 16'h7777);
        step();
        check("idle_setup_gnt", bus.b_gnt, 1);
        bus.b_req = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            check("idle_busy", bus.busy, 0);
            check("idle_mem_we", bus.mem_we, 0);
            check("idle_gnt", {bus.a_gnt, bus.b_gnt}, 0);
            check("idle_mem_addr", bus.mem_addr, 7);
        end

        check("a_exp_q_empty", a_exp_q.size(), 0);
        check("b_exp_q_empty", b_exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
